// File: rtl/collatz_pkg.sv
// rtl/collatz_pkg.sv - shared state encoding and error codes for the Collatz sequence engine
package collatz_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ERR_W = 2;

    localparam logic [ERR_W-1:0] ERR_NONE    = 2'd0;
    localparam logic [ERR_W-1:0] ERR_ZERO    = 2'd1;
    localparam logic [ERR_W-1:0] ERR_OVF     = 2'd2;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/collatz_seq_engine_if.sv
// rtl/collatz_seq_engine_if.sv - start/result bundle between a requester and the Collatz engine
interface collatz_seq_engine_if
    import collatz_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STEP_W = 10
);
    logic              start;
    logic [WIDTH-1:0]  n_in;
    logic              busy;
    logic              done;
    logic              valid;
    logic [STEP_W-1:0] steps;
    logic [WIDTH-1:0]  peak;
    logic [ERR_W-1:0]  err;

    // Requester side: issues start values, observes results.
    modport master (
        output start,
        output n_in,
        input  busy,
        input  done,
        input  valid,
        input  steps,
        input  peak,
        input  err
    );

    // Engine side: consumes start values, produces results.
    modport slave (
        input  start,
        input  n_in,
        output busy,
        output done,
        output valid,
        output steps,
        output peak,
        output err
    );
endinterface

// File: rtl/collatz_step.sv
// rtl/collatz_step.sv - combinational single Collatz step with overflow and termination flags
module collatz_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] next,
    output logic             ovf,
    output logic             is_one
);
    // 3n+1 is formed two bits wider so the top bits reveal when it leaves the WIDTH range.
    logic [WIDTH+1:0] n_wide;
    logic [WIDTH+1:0] triple_plus_one;

    assign n_wide          = {2'b00, n};
    assign triple_plus_one = (n_wide << 1) + n_wide + {{(WIDTH+1){1'b0}}, 1'b1};

    assign next   = n[0] ? triple_plus_one[WIDTH-1:0] : {1'b0, n[WIDTH-1:1]};
    assign ovf    = n[0] && (triple_plus_one[WIDTH+1:WIDTH] != 2'b00);
    assign is_one = (n == {{(WIDTH-1){1'b0}}, 1'b1});
endmodule

// File: rtl/collatz_seq_engine.sv
// rtl/collatz_seq_engine.sv - multi-cycle Collatz engine; COLLATZ_PEAK_EN enables peak tracking
module collatz_seq_engine
    import collatz_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int STEP_W    = 10,
    parameter int MAX_STEPS = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    collatz_seq_engine_if.slave  bus
);
    state_t            state;
    logic [WIDTH-1:0]  n_q;
    logic [STEP_W-1:0] steps_q;
    logic [ERR_W-1:0]  err_q;
    logic              busy_q;
    logic              done_q;
    logic              valid_q;

    logic [WIDTH-1:0]  n_next;
    logic              n_ovf;
    logic              n_is_one;
    logic              start_acc;
    logic              at_limit;

    collatz_step #(.WIDTH(WIDTH)) u_step (
        .n      (n_q),
        .next   (n_next),
        .ovf    (n_ovf),
        .is_one (n_is_one)
    );

    // A start only counts while idle or parked on a finished result.
    assign start_acc = bus.start && ((state == IDLE) || (state == DONE));
    assign at_limit  = (steps_q == STEP_W'(MAX_STEPS));

`ifdef COLLATZ_PEAK_EN
    logic [WIDTH-1:0] peak_q;

    // Running maximum of every value visited, seeded with the start value.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= '0;
        end else if (start_acc) begin
            peak_q <= bus.n_in;
        end else if (state == RUN && n_q != '0 && !n_is_one && !at_limit && !n_ovf
                     && n_next > peak_q) begin
            peak_q <= n_next;
        end
    end

    assign bus.peak = peak_q;
`else
    assign bus.peak = '0;
`endif

    // Sequencer and working registers; status flags lag the state by one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            n_q     <= '0;
            steps_q <= '0;
            err_q   <= ERR_NONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            busy_q  <= (state == RUN);
            valid_q <= (state == DONE) && !start_acc;
            done_q  <= (state == DONE) && !valid_q;

            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state   <= RUN;
                        n_q     <= bus.n_in;
                        steps_q <= '0;
                        err_q   <= ERR_NONE;
                    end
                end
                RUN: begin
                    if (n_q == '0) begin
                        err_q <= ERR_ZERO;
                        state <= DONE;
                    end else if (n_is_one) begin
                        state <= DONE;
                    end else if (at_limit) begin
                        err_q <= ERR_TIMEOUT;
                        state <= DONE;
                    end else if (n_ovf) begin
                        err_q <= ERR_OVF;
                        state <= DONE;
                    end else begin
                        n_q     <= n_next;
                        steps_q <= steps_q + STEP_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.valid = valid_q;
    assign bus.steps = steps_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_collatz_seq_engine.sv
// tb/tb_collatz_seq_engine.sv - self-checking bench for collatz_seq_engine
module tb_collatz_seq_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    collatz_seq_engine_if #(.WIDTH(16), .STEP_W(10)) ifa ();
    collatz_seq_engine_if #(.WIDTH(16), .STEP_W(10)) ifb ();

    collatz_seq_engine #(.WIDTH(16), .STEP_W(10), .MAX_STEPS(1000)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    collatz_seq_engine #(.WIDTH(16), .STEP_W(10), .MAX_STEPS(100)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: iterate the Collatz rule on plain integers.
    function automatic void model(input longint n0, input int maxs,
                                  output int st, output longint pk, output int er);
        longint n;
        longint nx;
        n  = n0;
        st = 0;
        pk = n0;
        er = 0;
        if (n0 == 0) begin
            er = 1;
            return;
        end
        while (n != 1) begin
            if (st == maxs) begin
                er = 3;
                break;
            end
            nx = (n % 2 == 1) ? 3 * n + 1 : n / 2;
            if (nx >= 65536) begin
                er = 2;
                break;
            end
            n = nx;
            st++;
            if (nx > pk) pk = nx;
        end
    endfunction

    task automatic sample(input int sel, output logic b, output logic d, output logic v,
                          output longint st, output longint pk, output longint er);
        if (sel == 0) begin
            b = ifa.busy; d = ifa.done; v = ifa.valid;
            st = ifa.steps; pk = ifa.peak; er = ifa.err;
        end else begin
            b = ifb.busy; d = ifb.done; v = ifb.valid;
            st = ifb.steps; pk = ifb.peak; er = ifb.err;
        end
    endtask

    task automatic set_start(input int sel, input logic s, input logic [15:0] v);
        if (sel == 0) begin
            ifa.start = s; ifa.n_in = v;
        end else begin
            ifb.start = s; ifb.n_in = v;
        end
    endtask

    // One transaction: pulse start, optionally re-poke start mid-run, check results and timing.
    task automatic run(input int sel, input int unsigned nv, input int maxs,
                       input int poke_at, input string tag);
        int     cnt;
        int     bcnt;
        int     est;
        longint epk;
        int     eer;
        logic   b, d, v;
        longint st, pk, er;
        logic [15:0] nv16;
        nv16 = nv[15:0];
        model(longint'(nv), maxs, est, epk, eer);
`ifndef COLLATZ_PEAK_EN
        epk = 0;
`endif
        @(negedge clk);
        set_start(sel, 1'b1, nv16);
        @(posedge clk);
        #1 set_start(sel, 1'b0, 16'h0);
        cnt  = 0;
        bcnt = 0;
        d    = 1'b0;
        while (cnt < 2000) begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt == poke_at) set_start(sel, 1'b1, 16'd7);
            else set_start(sel, 1'b0, 16'h0);
            sample(sel, b, d, v, st, pk, er);
            if (d) break;
            if (b) bcnt++;
        end
        set_start(sel, 1'b0, 16'h0);
        chk({tag, ".latency"}, cnt, est + 2);
        chk({tag, ".busy_cycles"}, bcnt, est + 1);
        chk({tag, ".steps"}, st, est);
        chk({tag, ".peak"}, pk, epk);
        chk({tag, ".err"}, er, eer);
        chk({tag, ".valid"}, v, 1);
        chk({tag, ".busy_in_done"}, b, 0);
        @(posedge clk);
        #1 sample(sel, b, d, v, st, pk, er);
        chk({tag, ".done_one_cycle"}, d, 0);
        chk({tag, ".valid_held"}, v, 1);
        chk({tag, ".steps_held"}, st, est);
    endtask

    initial begin
        logic   b, d, v;
        longint st, pk, er;
        int unsigned r;

        set_start(0, 1'b0, 16'h0);
        set_start(1, 1'b0, 16'h0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sample(0, b, d, v, st, pk, er);
        chk("reset.busy", b, 0);
        chk("reset.done", d, 0);
        chk("reset.valid", v, 0);
        chk("reset.steps", st, 0);
        chk("reset.peak", pk, 0);
        chk("reset.err", er, 0);
        rst = 1'b0;

        run(0, 6, 1000, 0, "n6");
        run(0, 27, 1000, 0, "n27");
        run(0, 1, 1000, 0, "n1");
        run(0, 0, 1000, 0, "n0");
        run(0, 65535, 1000, 0, "n65535");
        run(1, 27, 100, 0, "timeout27");
        run(0, 27, 1000, 10, "ignore_start");
        run(0, 7, 1000, 0, "from_done7");

        for (int i = 0; i < 8; i++) begin
            r = $urandom_range(65535, 1);
            run(0, r, 1000, 0, $sformatf("rand_a%0d", i));
        end
        for (int i = 0; i < 4; i++) begin
            r = $urandom_range(200, 2);
            run(1, r, 100, 0, $sformatf("rand_b%0d", i));
        end

        // Reset in the middle of a long run.
        @(negedge clk);
        set_start(0, 1'b1, 16'd27);
        @(posedge clk);
        #1 set_start(0, 1'b0, 16'h0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 sample(0, b, d, v, st, pk, er);
        chk("midrst.busy", b, 0);
        chk("midrst.done", d, 0);
        chk("midrst.valid", v, 0);
        chk("midrst.steps", st, 0);
        chk("midrst.peak", pk, 0);
        chk("midrst.err", er, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 sample(0, b, d, v, st, pk, er);
        chk("midrst.idle_busy", b, 0);
        chk("midrst.idle_valid", v, 0);

        run(0, 6, 1000, 0, "n6_again");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
